// File: rtl/seg16_pkg.sv
// seg16_pkg: shared types and constants for the 16-segment scan controller
package seg16_pkg;
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DECODE,
        ST_DRIVE,
        ST_GHOST
    } state_e;

    localparam logic [15:0] SEG_BLANK  = 16'h0000;
    localparam logic [7:0]  CHAR_SPACE = 8'h20;

    function automatic int idx_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    localparam int DEF_NUM_DIGITS = 6;
    localparam int DEF_IDX_W      = idx_width(DEF_NUM_DIGITS);
endpackage

// File: rtl/seg16_frame_buffer.sv
// seg16_frame_buffer: per-digit character store with host write port and read-before-write read port
module seg16_frame_buffer
    import seg16_pkg::*;
#(
    parameter int NUM_DIGITS = DEF_NUM_DIGITS,
    parameter int IDX_W      = DEF_IDX_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_valid,
    input  logic [IDX_W-1:0] wr_addr,
    input  logic [7:0]       wr_char,
    output logic             wr_err,
    input  logic [IDX_W-1:0] rd_addr,
    output logic [7:0]       rd_char
);
    logic [7:0] mem_q [NUM_DIGITS];
    logic [7:0] mem_d [NUM_DIGITS];
    logic       wr_err_q, wr_err_d;
    logic       wr_bad;

    always_comb begin
        wr_bad   = 32'(wr_addr) >= 32'(NUM_DIGITS);
        wr_err_d = wr_valid && wr_bad;
        mem_d    = mem_q;
        if (wr_valid && !wr_bad) mem_d[wr_addr] = wr_char;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_DIGITS; i++) mem_q[i] <= CHAR_SPACE;
            wr_err_q <= 1'b0;
        end else begin
            mem_q    <= mem_d;
            wr_err_q <= wr_err_d;
        end
    end

    // Reads the registered array, so a same-edge write is seen only afterwards
    assign rd_char = mem_q[rd_addr];
    assign wr_err  = wr_err_q;
endmodule

// File: rtl/seg16_scan_controller.sv
// seg16_scan_controller: time-multiplexed scan of an N-digit 16-segment display through one shared decoder
module seg16_scan_controller
    import seg16_pkg::*;
#(
    parameter int NUM_DIGITS   = 6,
    parameter int CLK_DIV      = 1000,
    parameter int BLANK_CYCLES = 2,
    parameter int IDX_W        = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    input  logic [IDX_W-1:0]      wr_addr,
    input  logic [7:0]            wr_char,
    output logic                  wr_err,
    output logic [7:0]            dec_char,
    input  logic [15:0]           dec_segment,
    input  logic                  dec_found,
    output logic [15:0]           seg_out,
    output logic [NUM_DIGITS-1:0] digit_en,
    output logic [NUM_DIGITS-1:0] miss_mask,
    output logic                  frame_done
);
    localparam int CNT_MAX = (CLK_DIV > BLANK_CYCLES) ? CLK_DIV : BLANK_CYCLES;
    localparam int CNT_W   = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX);
    localparam logic [CNT_W-1:0] DRIVE_LAST = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] GHOST_LAST = CNT_W'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);
    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

    state_e                state_q, state_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [7:0]            dec_char_q, dec_char_d;
    logic [15:0]           seg_q, seg_d;
    logic [NUM_DIGITS-1:0] digit_en_q, digit_en_d;
    logic [NUM_DIGITS-1:0] miss_q, miss_d;
    logic                  frame_done_q, frame_done_d;
    logic                  adv;
    logic [7:0]            rd_char;

    seg16_frame_buffer #(
        .NUM_DIGITS(NUM_DIGITS),
        .IDX_W     (IDX_W)
    ) u_buf (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_valid(wr_valid),
        .wr_addr (wr_addr),
        .wr_char (wr_char),
        .wr_err  (wr_err),
        .rd_addr (idx_q),
        .rd_char (rd_char)
    );

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        cnt_d        = cnt_q;
        dec_char_d   = dec_char_q;
        seg_d        = seg_q;
        digit_en_d   = digit_en_q;
        miss_d       = miss_q;
        frame_done_d = 1'b0;
        adv          = 1'b0;
        if (state_q != ST_IDLE && !enable) begin
            state_d    = ST_IDLE;
            idx_d      = '0;
            cnt_d      = '0;
            seg_d      = SEG_BLANK;
            digit_en_d = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = enable ? ST_FETCH : ST_IDLE;
                    idx_d   = '0;
                end
                ST_FETCH: begin
                    dec_char_d = rd_char;
                    state_d    = ST_DECODE;
                end
                ST_DECODE: begin
                    seg_d         = dec_found ? dec_segment : SEG_BLANK;
                    miss_d[idx_q] = ~dec_found;
                    digit_en_d    = NUM_DIGITS'(1) << idx_q;
                    cnt_d         = '0;
                    state_d       = ST_DRIVE;
                end
                ST_DRIVE: begin
                    cnt_d = (cnt_q == DRIVE_LAST) ? '0 : cnt_q + 1'b1;
                    if (cnt_q == DRIVE_LAST) begin
                        // Blank on the way out so the next digit never sees this pattern
                        seg_d      = SEG_BLANK;
                        digit_en_d = '0;
                        state_d    = ST_GHOST;
                        adv        = (BLANK_CYCLES == 0);
                    end
                end
                ST_GHOST: begin
                    cnt_d = (cnt_q == GHOST_LAST) ? '0 : cnt_q + 1'b1;
                    adv   = (cnt_q == GHOST_LAST);
                end
                default: state_d = ST_IDLE;
            endcase
            if (adv) begin
                state_d      = ST_FETCH;
                idx_d        = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
                frame_done_d = (idx_q == IDX_LAST);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            idx_q        <= '0;
            cnt_q        <= '0;
            dec_char_q   <= CHAR_SPACE;
            seg_q        <= SEG_BLANK;
            digit_en_q   <= '0;
            miss_q       <= '0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            cnt_q        <= cnt_d;
            dec_char_q   <= dec_char_d;
            seg_q        <= seg_d;
            digit_en_q   <= digit_en_d;
            miss_q       <= miss_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign wr_ready   = 1'b1;
    assign dec_char   = dec_char_q;
    assign seg_out    = seg_q;
    assign digit_en   = digit_en_q;
    assign miss_mask  = miss_q;
    assign frame_done = frame_done_q;
endmodule

// File: doc/seg16_scan_controller.md
Name: seg16_scan_controller

Overview:
- Time-multiplexed scan controller for an N-digit common-bus 16-segment display.
- Holds an N-character ASCII frame buffer that a host loads through a valid/ready write port.
- Sequences one shared ASCII-to-16-segment decoder across the digits and drives registered segment lines plus one-hot digit enables, with anti-ghosting dead time between digits.
- Sits between the host/character source and the display pins. The decoder is external and combinational.

Parameters:
- NUM_DIGITS, 6: number of display digits and buffer entries (2..8).
- CLK_DIV, 1000: clk cycles each digit is driven (>=1).
- BLANK_CYCLES, 2: dead cycles with all digits off between digits (>=0).
- IDX_W, 3: width of wr_addr and the internal digit index; ceil(log2(NUM_DIGITS)), minimum 1.

Ports:
- clk, input, 1: single system clock; all logic is on the rising edge.
- rst_n, input, 1: synchronous, active-low reset.
- enable, input, 1: scan enable; 0 blanks the display.
- wr_valid, input, 1: host write request.
- wr_ready, output, 1: controller can accept a write.
- wr_addr, input, IDX_W: buffer entry to write.
- wr_char, input, 8: ASCII character to store.
- wr_err, output, 1: one-cycle pulse when an accepted write had wr_addr >= NUM_DIGITS.
- dec_char, output, 8: character presented to the shared decoder.
- dec_segment, input, 16: decoder segment code.
- dec_found, input, 1: decoder hit flag.
- seg_out, output, 16: registered segment drive, active high.
- digit_en, output, NUM_DIGITS: registered one-hot digit select, active high.
- miss_mask, output, NUM_DIGITS: per-digit flag; 1 means the last decode of that digit missed.
- frame_done, output, 1: one-cycle pulse after the last digit's dead time completes.

Behaviour:
- Reset (rst_n=0 at a clk edge) applies the following regardless of state; a reset mid-scan aborts immediately with no partial frame_done:
  - All buffer entries are set to 8'h20.
  - seg_out=0, digit_en=0, miss_mask=0, dec_char=8'h20.
  - wr_ready=1, wr_err=0, frame_done=0.
  - State goes to IDLE, digit index to 0, counter to 0.
- Write port:
  - wr_ready is held at 1 whenever out of reset; a write completes on any cycle with wr_valid=1.
  - wr_addr < NUM_DIGITS: the entry updates at that edge.
  - wr_addr >= NUM_DIGITS: no update, and wr_err pulses on the next cycle.
  - Writes are accepted in every state.
  - A write to the entry being read in FETCH on the same edge: FETCH captures the old value; the new value is shown on the next frame.
- States:
  - IDLE: seg_out=0, digit_en=0. When enable=1, go to FETCH with index 0.
  - FETCH (1 cycle): dec_char <= buffer[idx]; digit_en=0. Go to DECODE.
  - DECODE (1 cycle): the decoder settles on dec_char. At the end of the cycle:
    - seg_out <= dec_found ? dec_segment : 16'h0000.
    - miss_mask[idx] <= ~dec_found.
    - digit_en <= one-hot(idx).
    - Go to DRIVE.
  - DRIVE (CLK_DIV cycles): seg_out and digit_en held stable; the counter runs 0..CLK_DIV-1.
    - If BLANK_CYCLES>0, go to GHOST.
    - Otherwise, advance directly (see index/advance rule).
  - GHOST (BLANK_CYCLES cycles): digit_en=0; seg_out=0 in the first GHOST cycle.
  - Index/advance rule: idx increments, and idx=NUM_DIGITS-1 wraps to 0 with frame_done pulsed for one cycle; then go to FETCH.
- Timing:
  - Digit period is 2+CLK_DIV+BLANK_CYCLES cycles.
  - Frame period is NUM_DIGITS times the digit period.
  - digit_en asserts 2 cycles after FETCH entry (FETCH + DECODE).
- enable=0 in any non-IDLE state:
  - Next edge: go to IDLE with seg_out=0, digit_en=0, idx=0.
  - No frame_done is issued.
  - miss_mask retains its values.
- Invariants:
  - digit_en is never multi-hot.
  - digit_en is never nonzero in FETCH, GHOST, or IDLE.
  - Counter wrap is exact, with no off-by-one across CLK_DIV=1.

Decomposition:
- Shared package seg16_pkg holds:
  - the state enum (IDLE, FETCH, DECODE, DRIVE, GHOST);
  - SEG_BLANK = 16'h0000;
  - CHAR_SPACE = 8'h20;
  - the NUM_DIGITS and IDX_W derivation.
- Natural sub-module: seg16_frame_buffer, the NUM_DIGITS x 8 register file with the write port, wr_err generation, and a read-before-write read port.
- The decoder stays outside the block and is instantiated alongside it at the top level.

Test Plan:
All scenarios use CLK_DIV=4, BLANK_CYCLES=1, NUM_DIGITS=6, giving a digit period of 7 and a frame of 42.
- Reset then enable=1 with the default buffer:
  - dec_char=8'h20 every FETCH; decoder misses, so seg_out=0.
  - miss_mask reaches 6'b111111 after one frame.
  - frame_done pulses every 42 cycles.
- Write "AB" to addresses 0 and 1, then scan:
  - Digit 0 drives seg_out=16'hF3C0 with digit_en=6'b000001 for 4 cycles.
  - Digit 1 drives 16'hFC52 with digit_en=6'b000010.
  - miss_mask[1:0] becomes 0.
- wr_valid with wr_addr=6 and wr_char="Z": no buffer change; wr_err pulses once; displayed pattern unchanged.
- Write 'Q' to digit 2 on the same edge as its FETCH:
  - The current frame shows the old code.
  - The next frame shows 16'hFF01.
- enable dropped during digit 3 DRIVE:
  - Next cycle: digit_en=0, seg_out=0, no frame_done.
  - Re-enable restarts at digit 0.
- rst_n=0 during DRIVE of digit 4:
  - Next edge: all outputs zero, buffer reads 8'h20, miss_mask=0.
